// File: rtl/ps2_command_tx.sv
// Purpose: host-to-device PS/2 transmitter: inhibit, request-to-send, 11-bit device-clocked frame, ACK check, timeout.
// Latency: INHIBIT_CYCLES of clock inhibit, then paced by the device clock; outcome pulse is registered.
// Backpressure: cmd_send is taken only while cmd_busy=0; requests during a transfer are dropped.
//
// Ports:
//   inclock, resetn        system clock, asynchronous active-low reset
//   ps2_clock, ps2_data    shared open-drain PS/2 lines (driven 0 or released)
//   cmd_data, cmd_send     command byte and start request
//   cmd_busy               transfer in progress
//   cmd_done, cmd_error    one-cycle outcome pulses (ACK received / timeout or missing ACK)
module ps2_command_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       inclock,
  input  logic       resetn,
  inout  wire        ps2_clock,
  inout  wire        ps2_data,
  input  logic [7:0] cmd_data,
  input  logic       cmd_send,
  output logic       cmd_busy,
  output logic       cmd_done,
  output logic       cmd_error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_DATA,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           state;
  logic             clk_drv_low;
  logic             dat_drv_low;
  logic             clk_meta, clk_sync, clk_prev;
  logic             dat_meta, dat_sync;
  logic             fe;
  logic [INH_W-1:0] inh_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [3:0]       fe_cnt;
  logic [8:0]       shift;

  // Open-drain drivers: only ever pull low, otherwise let the pull-up win.
  assign ps2_clock = clk_drv_low ? 1'b0 : 1'bz;
  assign ps2_data  = dat_drv_low ? 1'b0 : 1'bz;

  // Synchronizers reset to the idle (high) level so leaving reset never fakes an edge.
  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= ps2_clock;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= ps2_data;
      dat_sync <= dat_meta;
    end
  end

  assign fe = clk_prev & ~clk_sync;

  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      clk_drv_low <= 1'b0;
      dat_drv_low <= 1'b0;
      cmd_busy    <= 1'b0;
      cmd_done    <= 1'b0;
      cmd_error   <= 1'b0;
      inh_cnt     <= '0;
      tmo_cnt     <= '0;
      fe_cnt      <= '0;
      shift       <= '0;
    end else begin
      cmd_done  <= 1'b0;
      cmd_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_send) begin
            // Odd parity: the parity bit makes the total count of ones odd.
            shift       <= {~^cmd_data, cmd_data};
            inh_cnt     <= '0;
            clk_drv_low <= 1'b1;
            dat_drv_low <= 1'b0;
            cmd_busy    <= 1'b1;
            state       <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            // Request-to-send: start bit low, hand the clock to the device.
            clk_drv_low <= 1'b0;
            dat_drv_low <= 1'b1;
            fe_cnt      <= '0;
            tmo_cnt     <= '0;
            state       <= S_RTS;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end

        default: begin
          // Device-clocked phases share one watchdog on the gap between falling edges.
          if (fe) tmo_cnt <= '0;
          else    tmo_cnt <= tmo_cnt + 1'b1;

          if (!fe && tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            clk_drv_low <= 1'b0;
            dat_drv_low <= 1'b0;
            cmd_error   <= 1'b1;
            cmd_busy    <= 1'b0;
            tmo_cnt     <= '0;
            state       <= S_IDLE;
          end else begin
            case (state)
              S_RTS, S_DATA: begin
                if (fe) begin
                  fe_cnt <= fe_cnt + 1'b1;
                  if (fe_cnt == 4'd9) begin
                    // Tenth falling edge: stop bit is a released line.
                    dat_drv_low <= 1'b0;
                    state       <= S_ACK;
                  end else begin
                    // Edges 1..9 present data bits LSB first, then parity.
                    dat_drv_low <= ~shift[fe_cnt];
                    state       <= S_DATA;
                  end
                end
              end

              S_ACK: begin
                if (fe) begin
                  if (!dat_sync) begin
                    state <= S_WAIT_IDLE;
                  end else begin
                    cmd_error <= 1'b1;
                    cmd_busy  <= 1'b0;
                    state     <= S_IDLE;
                  end
                end
              end

              S_WAIT_IDLE: begin
                // Device must let both lines float back high before we report success.
                if (clk_sync && dat_sync) begin
                  cmd_done <= 1'b1;
                  cmd_busy <= 1'b0;
                  state    <= S_IDLE;
                end
              end

              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_command_tx.sv
`timescale 1ns/1ps
module tb_ps2_command_tx;

  localparam int INH = 10;
  localparam int TMO = 200;
  localparam int H   = 20;  // device clock half period in inclock cycles

  logic       inclock = 1'b0;
  logic       resetn  = 1'b1;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_send = 1'b0;
  logic       cmd_busy, cmd_done, cmd_error;
  wire        ps2_clock, ps2_data;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  assign ps2_clock = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_data  = dev_dat_low ? 1'b0 : 1'bz;
  pullup (ps2_clock);
  pullup (ps2_data);

  ps2_command_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .inclock   (inclock),
    .resetn    (resetn),
    .ps2_clock (ps2_clock),
    .ps2_data  (ps2_data),
    .cmd_data  (cmd_data),
    .cmd_send  (cmd_send),
    .cmd_busy  (cmd_busy),
    .cmd_done  (cmd_done),
    .cmd_error (cmd_error)
  );

  always #5 inclock = ~inclock;

  int cyc = 0;
  always @(posedge inclock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int last_fall_cyc = 0;

  // Outcome monitor, sampled 3 ns after each rising edge.
  int done_cnt = 0, err_cnt = 0, busy_low_cnt = 0, both_cnt = 0;
  always @(posedge inclock) begin
    #3;
    if (cmd_done === 1'b1) done_cnt++;
    if (cmd_error === 1'b1) err_cnt++;
    if (cmd_busy !== 1'b1) busy_low_cnt++;
    if (cmd_done === 1'b1 && cmd_error === 1'b1) both_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  // Reference: odd parity means the parity bit is 1 when the byte has an even count of ones.
  function automatic logic ref_parity(input logic [7:0] b);
    return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic tick();
    @(posedge inclock);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    tick();
    cmd_data = b;
    cmd_send = 1'b1;
    tick();
    cmd_send = 1'b0;
  endtask

  // Device model: waits for request-to-send (measuring how long the clock was inhibited),
  // then generates nclk clock pulses, sampling host data on each rising edge.
  task automatic dev_run(input int nclk, input bit ack, output logic [10:0] smp,
                         output int inh, output bit ok);
    int budget;
    smp = '0; inh = 0; ok = 1'b0; budget = 0;
    @(negedge inclock);
    while (!(ps2_clock === 1'b1 && ps2_data === 1'b0) && budget < 2000) begin
      if (ps2_clock === 1'b0) inh++;
      budget++;
      @(negedge inclock);
    end
    if (budget >= 2000) return;
    ok = 1'b1;
    for (int i = 1; i <= nclk; i++) begin
      repeat (H) tick();
      if (i == 11 && ack) dev_dat_low = 1'b1;
      dev_clk_low   = 1'b1;
      last_fall_cyc = cyc;
      repeat (H) tick();
      dev_clk_low = 1'b0;
      #1;
      smp[i-1] = ps2_data;
      if (i == 11) begin
        repeat (2) tick();
        dev_dat_low = 1'b0;
      end
    end
  endtask

  task automatic wait_outcome(input int d0, input int e0, output bit seen);
    int n;
    n = 0; seen = 1'b0;
    while (n < 3000) begin
      @(negedge inclock);
      if (done_cnt != d0 || err_cnt != e0) begin
        seen = 1'b1;
        break;
      end
      n++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    checks++; if (cmd_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", cmd_busy); end
    checks++; if (cmd_done !== 1'b0 || cmd_error !== 1'b0) begin errors++; $display("FAIL reset_pulses: done=%b error=%b want 0/0", cmd_done, cmd_error); end
    checks++; if (ps2_clock !== 1'b1 || ps2_data !== 1'b1) begin errors++; $display("FAIL reset_lines: clk=%b data=%b want released", ps2_clock, ps2_data); end
    resetn = 1'b1;
    repeat (3) tick();
    checks++; if (cmd_busy !== 1'b0 || cmd_done !== 1'b0 || cmd_error !== 1'b0) begin errors++; $display("FAIL post_reset_idle: busy=%b done=%b error=%b", cmd_busy, cmd_done, cmd_error); end
  endtask

  task automatic test_basic(input logic [7:0] b, input string nm);
    logic [10:0] smp; int inh; bit ok, seen; int d0, e0, bl0;
    d0 = done_cnt; e0 = err_cnt;
    send(b);
    bl0 = busy_low_cnt;
    dev_run(11, 1'b1, smp, inh, ok);
    wait_outcome(d0, e0, seen);
    checks++; if (!ok || !seen) begin errors++; $display("FAIL %s_progress: rts_seen=%b outcome_seen=%b want 1/1", nm, ok, seen); end
    checks++; if (inh != INH) begin errors++; $display("FAIL %s_inhibit: clock low %0d cycles want %0d", nm, inh, INH); end
    checks++; if (smp[7:0] !== b) begin errors++; $display("FAIL %s_data: got %h want %h", nm, smp[7:0], b); end
    checks++; if (smp[8] !== ref_parity(b)) begin errors++; $display("FAIL %s_parity: got %b want %b", nm, smp[8], ref_parity(b)); end
    checks++; if (smp[9] !== 1'b1) begin errors++; $display("FAIL %s_stop: got %b want 1", nm, smp[9]); end
    checks++; if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin errors++; $display("FAIL %s_outcome: done=%0d error=%0d want 1/0", nm, done_cnt - d0, err_cnt - e0); end
    checks++; if (busy_low_cnt - bl0 != 1) begin errors++; $display("FAIL %s_busy: busy low %0d cycles during transfer want 1 (done cycle)", nm, busy_low_cnt - bl0); end
    @(negedge inclock);
    checks++; if (cmd_busy !== 1'b0 || cmd_done !== 1'b0 || ps2_clock !== 1'b1 || ps2_data !== 1'b1) begin
      errors++; $display("FAIL %s_after: busy=%b done=%b clk=%b data=%b want 0/0/1/1", nm, cmd_busy, cmd_done, ps2_clock, ps2_data);
    end
  endtask

  task automatic test_no_ack();
    logic [10:0] smp; int inh; bit ok, seen; int d0, e0; logic [7:0] b;
    b = 8'($urandom);
    d0 = done_cnt; e0 = err_cnt;
    send(b);
    dev_run(11, 1'b0, smp, inh, ok);
    wait_outcome(d0, e0, seen);
    checks++; if (smp[7:0] !== b || smp[8] !== ref_parity(b)) begin errors++; $display("FAIL noack_frame: got %h/%b want %h/%b", smp[7:0], smp[8], b, ref_parity(b)); end
    checks++; if (!seen || err_cnt - e0 != 1 || done_cnt - d0 != 0) begin errors++; $display("FAIL noack_outcome: error=%0d done=%0d want 1/0", err_cnt - e0, done_cnt - d0); end
    @(negedge inclock);
    checks++; if (cmd_busy !== 1'b0 || ps2_clock !== 1'b1 || ps2_data !== 1'b1) begin errors++; $display("FAIL noack_release: busy=%b clk=%b data=%b want 0/1/1", cmd_busy, ps2_clock, ps2_data); end
  endtask

  task automatic test_timeout();
    logic [10:0] smp; int inh; bit ok, seen; int d0, e0, dt;
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    dev_run(4, 1'b1, smp, inh, ok);
    checks++; if (ps2_data !== 1'b0) begin errors++; $display("FAIL timeout_bit3_driven: data=%b want 0", ps2_data); end
    wait_outcome(d0, e0, seen);
    // Line fall -> two synchronizer stages -> counter runs TMO cycles -> registered pulse.
    dt = cyc - last_fall_cyc;
    checks++; if (!seen || dt != TMO + 3) begin errors++; $display("FAIL timeout_delay: error after %0d cycles want %0d", dt, TMO + 3); end
    checks++; if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin errors++; $display("FAIL timeout_outcome: error=%0d done=%0d want 1/0", err_cnt - e0, done_cnt - d0); end
    checks++; if (smp[3:0] !== 4'h4) begin errors++; $display("FAIL timeout_bits: got %h want 4", smp[3:0]); end
    @(negedge inclock);
    checks++; if (cmd_busy !== 1'b0 || ps2_clock !== 1'b1 || ps2_data !== 1'b1) begin errors++; $display("FAIL timeout_release: busy=%b clk=%b data=%b want 0/1/1", cmd_busy, ps2_clock, ps2_data); end
  endtask

  task automatic test_busy_ignore();
    logic [10:0] smp; int inh; bit ok, seen; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    fork
      dev_run(11, 1'b1, smp, inh, ok);
      begin
        repeat (60) tick();
        cmd_data = 8'h55;
        cmd_send = 1'b1;
        tick();
        cmd_send = 1'b0;
      end
    join
    wait_outcome(d0, e0, seen);
    checks++; if (smp[7:0] !== 8'hED || smp[8] !== ref_parity(8'hED)) begin errors++; $display("FAIL ignore_frame: got %h/%b want ed/%b", smp[7:0], smp[8], ref_parity(8'hED)); end
    checks++; if (!seen || done_cnt - d0 != 1 || err_cnt - e0 != 0) begin errors++; $display("FAIL ignore_outcome: done=%0d error=%0d want 1/0", done_cnt - d0, err_cnt - e0); end
    // New request on the first cycle after the done pulse.
    d0 = done_cnt; e0 = err_cnt;
    tick();
    cmd_data = 8'hF4;
    cmd_send = 1'b1;
    tick();
    cmd_send = 1'b0;
    @(negedge inclock);
    checks++; if (cmd_busy !== 1'b1) begin errors++; $display("FAIL next_accept: busy=%b want 1", cmd_busy); end
    dev_run(11, 1'b1, smp, inh, ok);
    wait_outcome(d0, e0, seen);
    checks++; if (smp[7:0] !== 8'hF4 || done_cnt - d0 != 1 || err_cnt - e0 != 0) begin errors++; $display("FAIL next_frame: data=%h done=%0d error=%0d want f4/1/0", smp[7:0], done_cnt - d0, err_cnt - e0); end
  endtask

  task automatic test_reset_mid();
    logic [10:0] smp; int inh; bit ok; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    dev_run(5, 1'b1, smp, inh, ok);
    #1;
    checks++; if (ps2_data !== 1'b0) begin errors++; $display("FAIL midreset_pre: data=%b want 0 (bit4 of ed)", ps2_data); end
    resetn = 1'b0;
    #1;
    checks++; if (ps2_data !== 1'b1 || ps2_clock !== 1'b1) begin errors++; $display("FAIL midreset_release: clk=%b data=%b want 1/1", ps2_clock, ps2_data); end
    checks++; if (cmd_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", cmd_busy); end
    repeat (3) tick();
    resetn = 1'b1;
    repeat (3) tick();
    checks++; if (done_cnt != d0 || err_cnt != e0) begin errors++; $display("FAIL midreset_pulses: done=%0d error=%0d want 0/0", done_cnt - d0, err_cnt - e0); end
    test_basic(8'hF4, "after_reset");
  endtask

  initial begin
    #1;
    test_reset();
    test_basic(8'hED, "ed");
    test_basic(8'hF4, "f4");
    for (int i = 0; i < 3; i++) test_basic(8'($urandom), "rand");
    test_no_ack();
    test_timeout();
    test_busy_ignore();
    test_reset_mid();
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL exclusive: done and error together %0d times want 0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
